// File: rtl/strait_pkg.sv
// strait_pkg: shared state/result types and a popcount helper for the STRAIT row matcher.
package strait_pkg;

    typedef enum logic [1:0] {ST_LOAD, ST_WAIT_ROW, ST_SEARCH, ST_ISSUE} frm_state_t;

    typedef enum logic [1:0] {RES_SUCCESS, RES_FAIL, RES_ALL} frm_result_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) c += 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/fault_mask_regfile.sv
// fault_mask_regfile: per-row faulty-PE column masks with one write port, one read port
// and a registered per-row "any fault" summary.
module fault_mask_regfile
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic [SYSTOLIC_SIZE-1:0] wr_mask,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic [SYSTOLIC_SIZE-1:0] rd_mask,
    output logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask
);

    logic [SYSTOLIC_SIZE-1:0] mask_q [SYSTOLIC_SIZE];
    logic [SYSTOLIC_SIZE-1:0] mask_d [SYSTOLIC_SIZE];
    logic [SYSTOLIC_SIZE-1:0] rows_q, rows_d;

    // The row summary follows the write data directly so it is final on the same edge as the mask.
    always_comb begin
        mask_d = mask_q;
        rows_d = rows_q;
        if (clear) begin
            for (int i = 0; i < SYSTOLIC_SIZE; i++) mask_d[i] = '0;
            rows_d = '0;
        end else if (wr_en) begin
            mask_d[wr_addr] = wr_mask;
            rows_d[wr_addr] = |wr_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '{default: '0};
            rows_q <= '0;
        end else begin
            mask_q <= mask_d;
            rows_q <= rows_d;
        end
    end

    assign rd_mask          = mask_q[rd_addr];
    assign faulty_rows_mask = rows_q;

endmodule

// File: rtl/faulty_row_matcher.sv
// faulty_row_matcher: maps weight rows onto faulty PE rows whose faults sit under zero weights.
// Define STRAIT_BEST_FIT_EN for a full best-fit scan (most faulty PEs); default is first-fit.
module faulty_row_matcher
    import strait_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     fault_wr_en,
    input  logic [ADDR_WIDTH-1:0]    fault_wr_addr,
    input  logic [SYSTOLIC_SIZE-1:0] fault_wr_mask,
    input  logic                     load_done,
    output logic                     envm_wr_en,
    output logic [SYSTOLIC_SIZE-1:0] faulty_rows_mask,
    input  logic                     row_valid,
    output logic                     row_ready,
    input  logic [ADDR_WIDTH-1:0]    row_addr,
    input  logic [SYSTOLIC_SIZE-1:0] row_zero_mask,
    output logic                     match_success,
    output logic                     match_failed,
    output logic                     all_faulty_matched,
    output logic [ADDR_WIDTH-1:0]    faulty_addr,
    output logic [ADDR_WIDTH-1:0]    current_row_addr,
    output logic                     all_matched,
    output logic                     busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    frm_state_t               state_q, state_d;
    frm_result_t              result_q, result_d;
    logic [ADDR_WIDTH-1:0]    scan_idx_q, scan_idx_d;
    logic [ADDR_WIDTH-1:0]    cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0]    faulty_addr_q, faulty_addr_d;
    logic [SYSTOLIC_SIZE-1:0] zero_mask_q, zero_mask_d;
    logic [SYSTOLIC_SIZE-1:0] matched_q, matched_d;
    logic                     envm_q, envm_d;
    logic [SYSTOLIC_SIZE-1:0] rd_mask;
    logic                     hit;

`ifdef STRAIT_BEST_FIT_EN
    localparam int CW = $clog2(SYSTOLIC_SIZE + 1);
    logic                  found_q, found_d;
    logic [ADDR_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [CW-1:0]         best_cnt_q, best_cnt_d;
    logic [CW-1:0]         cand_cnt;
    logic                  better;
    logic [ADDR_WIDTH-1:0] sel_idx;
`endif

    fault_mask_regfile #(
        .SYSTOLIC_SIZE(SYSTOLIC_SIZE),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_regfile (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .wr_en           (fault_wr_en && state_q == ST_LOAD && !clear),
        .wr_addr         (fault_wr_addr),
        .wr_mask         (fault_wr_mask),
        .rd_addr         (scan_idx_q),
        .rd_mask         (rd_mask),
        .faulty_rows_mask(faulty_rows_mask)
    );

    assign hit = faulty_rows_mask[scan_idx_q] && !matched_q[scan_idx_q]
                 && ((rd_mask & ~zero_mask_q) == '0);

`ifdef STRAIT_BEST_FIT_EN
    assign cand_cnt = CW'(popcount(32'(rd_mask)));
    assign better   = hit && (!found_q || cand_cnt > best_cnt_q);
    assign sel_idx  = better ? scan_idx_q : best_idx_q;
`endif

    always_comb begin
        state_d       = state_q;
        result_d      = result_q;
        scan_idx_d    = scan_idx_q;
        cur_addr_d    = cur_addr_q;
        faulty_addr_d = faulty_addr_q;
        zero_mask_d   = zero_mask_q;
        matched_d     = matched_q;
        envm_d        = 1'b0;
`ifdef STRAIT_BEST_FIT_EN
        found_d       = found_q;
        best_idx_d    = best_idx_q;
        best_cnt_d    = best_cnt_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_WAIT_ROW;
                    envm_d  = 1'b1;
                end
            end
            ST_WAIT_ROW: begin
                if (row_valid) begin
                    cur_addr_d  = row_addr;
                    zero_mask_d = row_zero_mask;
                    scan_idx_d  = '0;
                    state_d     = all_matched ? ST_ISSUE : ST_SEARCH;
                    result_d    = RES_ALL;
`ifdef STRAIT_BEST_FIT_EN
                    found_d     = 1'b0;
                    best_idx_d  = '0;
                    best_cnt_d  = '0;
`endif
                end
            end
            ST_SEARCH: begin
`ifdef STRAIT_BEST_FIT_EN
                found_d    = found_q || hit;
                best_idx_d = sel_idx;
                best_cnt_d = better ? cand_cnt : best_cnt_q;
                if (scan_idx_q == LAST) begin
                    state_d  = ST_ISSUE;
                    result_d = (found_q || hit) ? RES_SUCCESS : RES_FAIL;
                    if (found_q || hit) begin
                        faulty_addr_d      = sel_idx;
                        matched_d[sel_idx] = 1'b1;
                    end
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
`else
                if (hit) begin
                    state_d               = ST_ISSUE;
                    result_d              = RES_SUCCESS;
                    faulty_addr_d         = scan_idx_q;
                    matched_d[scan_idx_q] = 1'b1;
                end else if (scan_idx_q == LAST) begin
                    state_d  = ST_ISSUE;
                    result_d = RES_FAIL;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_WAIT_ROW;
        endcase
        // Clear wins over everything, including an in-flight search, so no result is issued.
        if (clear) begin
            state_d       = ST_LOAD;
            result_d      = RES_SUCCESS;
            scan_idx_d    = '0;
            cur_addr_d    = '0;
            faulty_addr_d = '0;
            zero_mask_d   = '0;
            matched_d     = '0;
            envm_d        = 1'b0;
`ifdef STRAIT_BEST_FIT_EN
            found_d       = 1'b0;
            best_idx_d    = '0;
            best_cnt_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_LOAD;
            result_q      <= RES_SUCCESS;
            scan_idx_q    <= '0;
            cur_addr_q    <= '0;
            faulty_addr_q <= '0;
            zero_mask_q   <= '0;
            matched_q     <= '0;
            envm_q        <= 1'b0;
`ifdef STRAIT_BEST_FIT_EN
            found_q       <= 1'b0;
            best_idx_q    <= '0;
            best_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            result_q      <= result_d;
            scan_idx_q    <= scan_idx_d;
            cur_addr_q    <= cur_addr_d;
            faulty_addr_q <= faulty_addr_d;
            zero_mask_q   <= zero_mask_d;
            matched_q     <= matched_d;
            envm_q        <= envm_d;
`ifdef STRAIT_BEST_FIT_EN
            found_q       <= found_d;
            best_idx_q    <= best_idx_d;
            best_cnt_q    <= best_cnt_d;
`endif
        end
    end

    assign envm_wr_en         = envm_q;
    assign row_ready          = state_q == ST_WAIT_ROW;
    assign busy               = state_q == ST_SEARCH || state_q == ST_ISSUE;
    assign match_success      = state_q == ST_ISSUE && result_q == RES_SUCCESS;
    assign match_failed       = state_q == ST_ISSUE && result_q == RES_FAIL;
    assign all_faulty_matched = state_q == ST_ISSUE && result_q == RES_ALL;
    assign faulty_addr        = faulty_addr_q;
    assign current_row_addr   = cur_addr_q;
    // Gated by state so the empty-vs-empty compare during LOAD does not read as "all matched".
    assign all_matched        = state_q != ST_LOAD && matched_q == faulty_rows_mask;

endmodule

// File: tb/tb_faulty_row_matcher.sv
// tb_faulty_row_matcher: directed scoreboard bench for faulty_row_matcher (SYSTOLIC_SIZE=8).
module tb_faulty_row_matcher;

    localparam int N  = 8;
    localparam int AW = 3;
`ifdef STRAIT_BEST_FIT_EN
    localparam bit BF = 1'b1;
`else
    localparam bit BF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          fault_wr_en = 1'b0;
    logic [AW-1:0] fault_wr_addr = '0;
    logic [N-1:0]  fault_wr_mask = '0;
    logic          load_done = 1'b0;
    logic          row_valid = 1'b0;
    logic [AW-1:0] row_addr = '0;
    logic [N-1:0]  row_zero_mask = '0;
    logic          envm_wr_en, row_ready, match_success, match_failed;
    logic          all_faulty_matched, all_matched, busy;
    logic [N-1:0]  faulty_rows_mask;
    logic [AW-1:0] faulty_addr, current_row_addr;

    typedef struct {
        logic [2:0] kind;
        int         faddr;
        int         caddr;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cmp_n = 0;
    int   err_n = 0;

    localparam logic [2:0] K_OK = 3'b100, K_FAIL = 3'b010, K_ALL = 3'b001;

    faulty_row_matcher #(.SYSTOLIC_SIZE(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clear             (clear),
        .fault_wr_en       (fault_wr_en),
        .fault_wr_addr     (fault_wr_addr),
        .fault_wr_mask     (fault_wr_mask),
        .load_done         (load_done),
        .envm_wr_en        (envm_wr_en),
        .faulty_rows_mask  (faulty_rows_mask),
        .row_valid         (row_valid),
        .row_ready         (row_ready),
        .row_addr          (row_addr),
        .row_zero_mask     (row_zero_mask),
        .match_success     (match_success),
        .match_failed      (match_failed),
        .all_faulty_matched(all_faulty_matched),
        .faulty_addr       (faulty_addr),
        .current_row_addr  (current_row_addr),
        .all_matched       (all_matched),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_n++;
        assert (got === exp) else begin
            err_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_row(input logic [AW-1:0] a, input logic [N-1:0] m);
        @(negedge clk);
        fault_wr_en   = 1'b1;
        fault_wr_addr = a;
        fault_wr_mask = m;
        @(negedge clk);
        fault_wr_en   = 1'b0;
    endtask

    task automatic finish_load(input logic [N-1:0] exp_rows);
        @(negedge clk);
        load_done = 1'b1;
        @(negedge clk);
        load_done = 1'b0;
        chk("envm_pulse", 32'(envm_wr_en), 1);
        chk("faulty_rows_mask", 32'(faulty_rows_mask), 32'(exp_rows));
        @(negedge clk);
        chk("envm_single", 32'(envm_wr_en), 0);
        chk("row_ready_after_load", 32'(row_ready), 1);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_rows", 32'(faulty_rows_mask), 0);
        chk("clear_ready", 32'(row_ready), 0);
        chk("clear_all_matched", 32'(all_matched), 0);
    endtask

    task automatic offer(input logic [AW-1:0] a, input logic [N-1:0] zm);
        @(negedge clk);
        row_valid     = 1'b1;
        row_addr      = a;
        row_zero_mask = zm;
        chk("ready_before_accept", 32'(row_ready), 1);
        @(posedge clk);
        #1 row_valid = 1'b0;
    endtask

    // Waits for a result pulse; cycle n is the n-th clock period after the acceptance edge.
    task automatic collect(input int bound);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int n = 1; n <= bound && !seen; n++) begin
            @(negedge clk);
            if (match_success || match_failed || all_faulty_matched) begin
                seen = 1'b1;
                if (sb.size() == 0) chk("unexpected_pulse", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("result_kind", 32'({match_success, match_failed, all_faulty_matched}), 32'(e.kind));
                    chk("result_cycle", n, e.cyc);
                    chk("current_row_addr", 32'(current_row_addr), e.caddr);
                    if (e.kind == K_OK) chk("faulty_addr", 32'(faulty_addr), e.faddr);
                end
            end
        end
        if (!seen && sb.size() != 0) begin
            chk("result_timeout", 0, 1);
            void'(sb.pop_front());
        end
    endtask

    task automatic send_row(input logic [AW-1:0] a, input logic [N-1:0] zm,
                            input logic [2:0] kind, input int fa, input int cyc);
        exp_t e;
        e.kind  = kind;
        e.faddr = fa;
        e.caddr = a;
        e.cyc   = cyc;
        sb.push_back(e);
        offer(a, zm);
        collect(20);
        @(negedge clk);
        chk("ready_after_pulse", 32'(row_ready), 1);
        chk("pulse_cleared", 32'({match_success, match_failed, all_faulty_matched}), 0);
        chk("row_addr_stable", 32'(current_row_addr), 32'(a));
        if (kind == K_OK) chk("faulty_addr_stable", 32'(faulty_addr), fa);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({envm_wr_en, faulty_rows_mask, match_success, match_failed,
                                  all_faulty_matched, faulty_addr, current_row_addr,
                                  all_matched, busy}), 0);
        chk("reset_ready", 32'(row_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(row_ready), 0);
        chk("idle_busy", 32'(busy), 0);

        load_row(3'd2, 8'b0000_0100);
        load_row(3'd5, 8'b0011_0000);
        finish_load(8'b0010_0100);
        load_row(3'd0, 8'hFF);
        chk("write_after_load_ignored", 32'(faulty_rows_mask), 32'h24);

        send_row(3'd0, 8'b0000_0100, K_OK, 2, BF ? 9 : 4);
        chk("partial_all_matched", 32'(all_matched), 0);
        send_row(3'd1, 8'h00, K_FAIL, 0, 9);
        send_row(3'd3, 8'b0011_0000, K_OK, 5, BF ? 9 : 7);
        chk("all_matched_set", 32'(all_matched), 1);
        send_row(3'd4, 8'h5A, K_ALL, 0, 1);

        do_clear();
        load_row(3'd1, 8'b01);
        load_row(3'd3, 8'b11);
        finish_load(8'b0000_1010);
        send_row(3'd2, 8'b11, K_OK, BF ? 3 : 1, BF ? 9 : 3);
        send_row(3'd5, 8'b11, K_OK, BF ? 1 : 3, BF ? 9 : 5);
        send_row(3'd6, 8'h00, K_ALL, 0, 1);

        do_clear();
        load_row(3'd1, 8'b01);
        load_row(3'd3, 8'b11);
        finish_load(8'b0000_1010);
        offer(3'd7, 8'b11);
        @(negedge clk);
        chk("busy_in_search", 32'(busy), 1);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_no_pulse", 32'({match_success, match_failed, all_faulty_matched}), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(row_ready), 0);
        chk("abort_rows", 32'(faulty_rows_mask), 0);
        collect(12);
        chk("abort_stays_load", 32'({row_ready, busy}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
